imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_word_assembler.sv | 31 +++
 rtl/imem_loader.sv | 125 ++++++++++++
 tb/tb_imem_loader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package imem_loader_pkg;

    // Loader FSM states.
    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CHK,
        DONE,
        ERROR
    } state_t;

    // Bytes in the little-endian length header and in each instruction word.
    localparam int LEN_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word assembler shared by length and data capture.
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [1:0]  last_index,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [1:0]  count;
    logic [31:0] shreg;

    // The newest byte enters at the top, so after four shifts byte 0 sits in bits 7:0.
    assign word       = {byte_in, shreg[31:8]};
    assign word_ready = shift_en && (count == last_index);

    // Byte counter and shift register; the counter restarts after the last byte of a word.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= 2'd0;
            shreg <= 32'd0;
        end else if (shift_en) begin
            shreg <= word;
            count <= word_ready ? 2'd0 : count + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, checksummed image into instruction memory and
// releases the core from reset once the whole image has been verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wd,
    output logic        core_reset,
    output logic        done,
    output logic        error
);

    // One extra bit so a full DEPTH-word image never wraps the word index.
    localparam int CNT_W = ADDR_W + 1;

    state_t             state;
    logic [CNT_W-1:0]   word_idx;
    logic [CNT_W-1:0]   word_count;
    logic [7:0]         xor_acc;
    logic               accept;
    logic               shift_en;
    logic               word_ready;
    logic [31:0]        word;
    logic [1:0]         last_index;

    assign rx_ready   = ((state == LEN) || (state == DATA) || (state == CHK)) && !start;
    assign accept     = rx_valid && rx_ready;
    assign shift_en   = accept && ((state == LEN) || (state == DATA));
    assign last_index = (state == LEN) ? 2'(LEN_BYTES - 1) : 2'(BYTES_PER_WORD - 1);

    word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (start),
        .shift_en   (shift_en),
        .last_index (last_index),
        .byte_in    (rx_data),
        .word       (word),
        .word_ready (word_ready)
    );

    // Loader FSM with registered memory-write and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            word_idx   <= '0;
            word_count <= '0;
            xor_acc    <= 8'd0;
            imem_we    <= 1'b0;
            imem_addr  <= 32'd0;
            imem_wd    <= 32'd0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (start) begin
                state      <= LEN;
                word_idx   <= '0;
                xor_acc    <= 8'd0;
                done       <= 1'b0;
                error      <= 1'b0;
                core_reset <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    LEN: begin
                        if (word_ready) begin
                            if (word > 32'(DEPTH)) begin
                                state <= ERROR;
                                error <= 1'b1;
                            end else if (word == 32'd0) begin
                                state <= CHK;
                            end else begin
                                state      <= DATA;
                                word_count <= word[CNT_W-1:0];
                            end
                        end
                    end
                    DATA: begin
                        if (accept) begin
                            xor_acc <= xor_acc ^ rx_data;
                            if (word_ready) begin
                                imem_we   <= 1'b1;
                                imem_addr <= {{(32-CNT_W-2){1'b0}}, word_idx, 2'b00};
                                imem_wd   <= word;
                                word_idx  <= word_idx + CNT_W'(1);
                                if (word_idx == word_count - CNT_W'(1)) begin
                                    state <= CHK;
                                end
                            end
                        end
                    end
                    CHK: begin
                        if (accept) begin
                            if (rx_data == xor_acc) begin
                                state      <= DONE;
                                done       <= 1'b1;
                                core_reset <= 1'b0;
                            end else begin
                                state <= ERROR;
                                error <= 1'b1;
                            end
                        end
                    end
                    DONE, ERROR: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a stream-level model predicts the
// writes and status, and a per-cycle compare process checks the DUT.
module tb_imem_loader;

    localparam int DEPTH = 64;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wd;
    logic        core_reset;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    // Model state: expected status plus the queue of writes still owed.
    logic exp_busy;
    logic exp_core_reset;
    logic exp_done;
    logic exp_error;
    logic chk_en;
    wr_t  exp_q[$];
    wr_t  wr_log[$];
    logic [7:0] stream[$];

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wd    (imem_wd),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout reached before end of test");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every output against the model.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            #1;
            if (chk_en) begin
                checkOutput("rx_ready", 32'(rx_ready), 32'(exp_busy && !start));
                checkOutput("core_reset", 32'(core_reset), 32'(exp_core_reset));
                checkOutput("done", 32'(done), 32'(exp_done));
                checkOutput("error", 32'(error), 32'(exp_error));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("imem_we", 32'(imem_we), 32'd1);
                    checkOutput("imem_addr", imem_addr, e.addr);
                    checkOutput("imem_wd", imem_wd, e.data);
                end else begin
                    checkOutput("imem_we_idle", 32'(imem_we), 32'd0);
                end
                if (imem_we) wr_log.push_back('{imem_addr, imem_wd});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input logic with_valid);
        @(negedge clk);
        start    = 1'b1;
        rx_valid = with_valid;
        rx_data  = 8'hAA;
        @(posedge clk);
        exp_busy       = 1'b1;
        exp_done       = 1'b0;
        exp_error      = 1'b0;
        exp_core_reset = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        rx_valid = 1'b0;
        wr_log.delete();
    endtask

    // Streams the bytes in 'stream' and decodes them at the image level to
    // predict writes and final status.
    task automatic applyStimulus(input int max_gap);
        logic [31:0] lenv = 32'd0;
        logic [31:0] wbuf = 32'd0;
        logic [7:0]  xr   = 8'd0;
        logic [7:0]  b;
        int          gap;
        int          d;
        for (int k = 0; k < stream.size(); k++) begin
            b   = stream[k];
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            send_byte(b, gap);
            if (k < 4) begin
                lenv[8*k +: 8] = b;
                if (k == 3 && longint'(lenv) > longint'(DEPTH)) begin
                    exp_error = 1'b1;
                    exp_busy  = 1'b0;
                    break;
                end
            end else if (longint'(k) < 4 + 4 * longint'(lenv)) begin
                d  = k - 4;
                xr = xr ^ b;
                wbuf[8*(d%4) +: 8] = b;
                if (d % 4 == 3) exp_q.push_back('{32'(4 * (d / 4)), wbuf});
            end else begin
                exp_busy = 1'b0;
                if (b == xr) begin
                    exp_done       = 1'b1;
                    exp_core_reset = 1'b0;
                end else begin
                    exp_error = 1'b1;
                end
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic make_image(input int n, input bit bad);
        logic [7:0]  x = 8'd0;
        logic [31:0] w;
        stream.delete();
        for (int b = 0; b < 4; b++) stream.push_back(8'(n >> (8 * b)));
        for (int i = 0; i < n; i++) begin
            w = {8'(i), 8'h5A, 8'(i * 7 + 1), 8'h13};
            for (int b = 0; b < 4; b++) begin
                stream.push_back(w[8*b +: 8]);
                x = x ^ w[8*b +: 8];
            end
        end
        stream.push_back(bad ? ~x : x);
    endtask

    // Directed test sequence.
    initial begin
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; chk_en = 1'b0;
        exp_busy = 1'b0; exp_core_reset = 1'b1; exp_done = 1'b0; exp_error = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_rx_ready", 32'(rx_ready), 32'd0);
        checkOutput("rst_imem_we", 32'(imem_we), 32'd0);
        checkOutput("rst_imem_addr", imem_addr, 32'd0);
        checkOutput("rst_imem_wd", imem_wd, 32'd0);
        checkOutput("rst_core_reset", 32'(core_reset), 32'd1);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Two-word image; XOR of the eight data bytes is 0xB0.
        $display("[TB] two-word image");
        do_start(1'b0);
        stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                   8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
        applyStimulus(0);
        idle(2);
        checkOutput("t1_write_count", 32'(wr_log.size()), 32'd2);
        if (wr_log.size() == 2) begin
            checkOutput("t1_wr0_addr", wr_log[0].addr, 32'h0);
            checkOutput("t1_wr0_data", wr_log[0].data, 32'h00100513);
            checkOutput("t1_wr1_addr", wr_log[1].addr, 32'h4);
            checkOutput("t1_wr1_data", wr_log[1].data, 32'h00200593);
        end
        checkOutput("t1_done", 32'(done), 32'd1);
        checkOutput("t1_core_reset", 32'(core_reset), 32'd0);

        // Same image with a wrong checksum.
        $display("[TB] bad checksum");
        do_start(1'b0);
        stream[12] = 8'h00;
        applyStimulus(0);
        idle(2);
        checkOutput("t2_error", 32'(error), 32'd1);
        checkOutput("t2_done", 32'(done), 32'd0);
        checkOutput("t2_core_reset", 32'(core_reset), 32'd1);

        // Length DEPTH+1 overflows, then a valid one-word reload.
        $display("[TB] length overflow then reload");
        do_start(1'b0);
        stream = '{8'(DEPTH + 1), 8'h00, 8'h00, 8'h00};
        applyStimulus(0);
        idle(3);
        checkOutput("t3_error", 32'(error), 32'd1);
        checkOutput("t3_no_writes", 32'(wr_log.size()), 32'd0);
        do_start(1'b0);
        make_image(1, 1'b0);
        applyStimulus(0);
        idle(2);
        checkOutput("t3_reload_done", 32'(done), 32'd1);

        // Overflow carried only by a high length bit (N = 65536).
        $display("[TB] high-bit length overflow");
        do_start(1'b0);
        stream = '{8'h00, 8'h00, 8'h01, 8'h00};
        applyStimulus(0);
        idle(2);
        checkOutput("t4_error", 32'(error), 32'd1);

        // Empty image.
        $display("[TB] zero-length image");
        do_start(1'b0);
        stream = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(0);
        idle(2);
        checkOutput("t5_done", 32'(done), 32'd1);
        checkOutput("t5_no_writes", 32'(wr_log.size()), 32'd0);

        // Restart in the middle of data with a byte offered in the start cycle.
        $display("[TB] restart mid-data");
        do_start(1'b0);
        make_image(3, 1'b0);
        stream = stream[0:9];
        applyStimulus(0);
        do_start(1'b1);
        make_image(2, 1'b0);
        applyStimulus(0);
        idle(2);
        checkOutput("t6_done", 32'(done), 32'd1);
        checkOutput("t6_write_count", 32'(wr_log.size()), 32'd2);

        // Full-capacity image with random gaps between bytes.
        $display("[TB] full-depth image with gaps");
        do_start(1'b0);
        make_image(DEPTH, 1'b0);
        applyStimulus(3);
        idle(2);
        checkOutput("t7_write_count", 32'(wr_log.size()), 32'(DEPTH));
        if (wr_log.size() > 0)
            checkOutput("t7_last_addr", wr_log[wr_log.size()-1].addr, 32'd252);
        checkOutput("t7_done", 32'(done), 32'd1);
        checkOutput("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
